// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings, FSM states
// and the magnitude/sign helpers used to run signed ops on an unsigned datapath.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_MADD  = 3'd2;
    localparam logic [2:0] MDU_MADDU = 3'd3;
    localparam logic [2:0] MDU_MSUB  = 3'd4;
    localparam logic [2:0] MDU_MSUBU = 3'd5;
    localparam logic [2:0] MDU_DIV   = 3'd6;
    localparam logic [2:0] MDU_DIVU  = 3'd7;

    typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, DONE} mdu_state_t;

    // Helpers work on a wide scratch width; callers keep only the low bits they need.
    localparam int MDU_XW = 128;

    function automatic logic [MDU_XW-1:0] mdu_negate(input logic [MDU_XW-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [MDU_XW-1:0] mdu_cond_neg(input logic [MDU_XW-1:0] v, input logic neg);
        return neg ? mdu_negate(v) : v;
    endfunction

    function automatic logic [MDU_XW-1:0] mdu_abs(input logic [MDU_XW-1:0] v, input int w,
                                                   input logic is_signed);
        return mdu_cond_neg(v, is_signed && v[w-1]);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return op inside {MDU_MULT, MDU_MADD, MDU_MSUB, MDU_DIV};
    endfunction

    function automatic logic mdu_is_acc(input logic [2:0] op);
        return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic mdu_is_sub(input logic [2:0] op);
        return op inside {MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider producing one quotient bit per cycle for WIDTH cycles.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted, trial;

    // quotient/remainder show the result of the step in progress, so on the
    // done cycle they already carry the final values.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvs_q};
    assign quotient  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign remainder = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign done      = busy && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (annul) begin
            busy <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: signed ops run on magnitudes with the sign
// restored at the end; results return as {HI,LO} with a one-cycle valid pulse.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               valid_o,
    output logic               dbz_o,
    output logic               busy_o,
    output logic               stallreq_o
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    mdu_state_t       state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, rem_neg_q;
    logic [DW-1:0]    hilo_q, prod_q;
    logic [CNT_W-1:0] cnt;

    logic              accept, in_signed, div_zero, div_start;
    logic              div_busy, div_done;
    logic [WIDTH-1:0]  div_quo, div_rem;
    logic [DW-1:0]     prod_raw, prod_mag;
    logic [MDU_XW-1:0] a_abs_x, b_abs_x, prod_fix_x, q_fix_x, r_fix_x;
    logic              unused_bits;

    assign accept     = (state == IDLE) && start_i && !annul_i;
    assign in_signed  = mdu_is_signed(op_i);
    assign div_zero   = (opb_i == '0);
    assign div_start  = accept && mdu_is_div(op_i) && !div_zero;
    assign a_abs_x    = mdu_abs(MDU_XW'(opa_i), WIDTH, in_signed);
    assign b_abs_x    = mdu_abs(MDU_XW'(opb_i), WIDTH, in_signed);
    assign prod_raw   = DW'(a_mag) * DW'(b_mag);
    assign prod_fix_x = mdu_cond_neg(MDU_XW'(prod_mag), neg_q);
    assign q_fix_x    = mdu_cond_neg(MDU_XW'(div_quo), neg_q);
    assign r_fix_x    = mdu_cond_neg(MDU_XW'(div_rem), rem_neg_q);

    assign valid_o    = (state == DONE);
    assign busy_o     = (state != IDLE);
    assign stallreq_o = accept || (state inside {MUL, ACC, DIV});

    assign unused_bits = ^{a_abs_x[MDU_XW-1:WIDTH], b_abs_x[MDU_XW-1:WIDTH],
                           prod_fix_x[MDU_XW-1:DW], q_fix_x[MDU_XW-1:WIDTH],
                           r_fix_x[MDU_XW-1:WIDTH], div_busy};

    // The operand registers form the first multiplier stage; the remaining
    // MUL_LAT-1 stages are plain registers that synthesis can retime.
    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign prod_mag = prod_raw;
        end else begin : g_mul_pipe
            logic [DW-1:0] pipe [MUL_LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < MUL_LAT - 1; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= prod_raw;
                    for (int k = 1; k < MUL_LAT - 1; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign prod_mag = pipe[MUL_LAT-2];
        end
    endgenerate

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .annul     (annul_i),
        .dividend  (a_abs_x[WIDTH-1:0]),
        .divisor   (b_abs_x[WIDTH-1:0]),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (mdu_is_div(op_i)) state_nxt = div_zero ? DONE : DIV;
                else                  state_nxt = MUL;
            end
            MUL:  if (cnt == CNT_LAST) state_nxt = mdu_is_acc(op_q) ? ACC : DONE;
            ACC:  state_nxt = DONE;
            DIV:  if (div_done) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul_i) state_nxt = IDLE;
    end

    // result_o only changes on the way into DONE, so it holds across idle periods
    // and an annulled operation leaves the previous result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hilo_q    <= '0;
            prod_q    <= '0;
            cnt       <= '0;
            result_o  <= '0;
            dbz_o     <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= op_i;
                a_mag     <= a_abs_x[WIDTH-1:0];
                b_mag     <= b_abs_x[WIDTH-1:0];
                neg_q     <= in_signed && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                rem_neg_q <= in_signed && opa_i[WIDTH-1];
                hilo_q    <= hilo_i;
                cnt       <= '0;
                dbz_o     <= 1'b0;
                if (mdu_is_div(op_i) && div_zero) begin
                    result_o <= {opa_i, {WIDTH{1'b1}}};
                    dbz_o    <= 1'b1;
                end
            end
            if (state == MUL) begin
                cnt <= cnt + 1'b1;
            end
            if (!annul_i) begin
                if (state == MUL && cnt == CNT_LAST) begin
                    if (mdu_is_acc(op_q)) prod_q   <= prod_fix_x[DW-1:0];
                    else                  result_o <= prod_fix_x[DW-1:0];
                end
                if (state == ACC) begin
                    result_o <= mdu_is_sub(op_q) ? hilo_q - prod_q : hilo_q + prod_q;
                end
                if (state == DIV && div_done) begin
                    result_o <= {r_fix_x[WIDTH-1:0], q_fix_x[WIDTH-1:0]};
                end
            end
        end
    end

endmodule
